// File: rtl/port_b_reader.sv
// Read-only BRAM port-B burst initiator.
// Streams words from consecutive addresses over a valid/ready output.
module port_b_reader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [WIDTH-1:0] length,
  output logic [WIDTH-1:0] addr_b,
  output logic             we_b,
  output logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] VALID  = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [2:0]       state;
  logic [WIDTH-1:0] cur_addr;
  logic [WIDTH-1:0] count;

  assign addr_b    = cur_addr;
  assign we_b      = 1'b0;
  assign data_b    = '0;
  assign out_valid = (state == VALID);
  assign busy      = (state == ISSUE) ||
                     (state == WAIT)  ||
                     (state == VALID);
  assign done      = (state == FINISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cur_addr <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              cur_addr <= base_addr;
              count    <= length;
              state    <= ISSUE;
            end else begin
              state <= FINISH;
            end
          end
        end
        ISSUE: state <= abort ? IDLE : WAIT;
        WAIT: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            out_data <= q_b;
            state    <= VALID;
          end
        end
        VALID: begin
          // a transfer landing with abort still counts as delivered
          if (out_ready) begin
            count    <= count - ONE;
            cur_addr <= cur_addr + ONE;
          end
          if (abort)
            state <= IDLE;
          else if (out_ready)
            state <= (count == ONE) ? FINISH : ISSUE;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/port_b_reader.md
PORT_B_READER -- requirements
Module: port_b_reader

Interface
REQ-001 Parameter WIDTH, default 16, data and address width of BRAM port B.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
REQ-004 start  input  1  request a burst; sampled only in IDLE.
REQ-005 abort  input  1  cancel the active burst.
REQ-006 base_addr  input  WIDTH  first word address of the burst; latched on accepted start.
REQ-007 length  input  WIDTH  number of words to read; latched on accepted start.
REQ-008 addr_b  output  WIDTH  BRAM port-B address.
REQ-009 we_b  output  1  BRAM port-B write enable.
REQ-010 data_b  output  WIDTH  BRAM port-B write data.
REQ-011 q_b  input  WIDTH  BRAM port-B read data.
REQ-012 out_data  output  WIDTH  streamed word.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_ready  input  1  consumer accepts out_data.
REQ-015 busy  output  1  burst in progress.
REQ-016 done  output  1  one-cycle pulse on burst completion.

Function
REQ-017 The block SHALL be a read-only port-B initiator: we_b SHALL be 0 and data_b SHALL be 0 at all times.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, VALID, FINISH.
REQ-019 In IDLE, start=1 with length!=0 SHALL latch base_addr into cur_addr and length into count, then go to ISSUE.
REQ-020 In IDLE, start=1 with length=0 SHALL go to FINISH with no BRAM read.
REQ-021 addr_b SHALL be driven from registered cur_addr in every state.
REQ-022 ISSUE SHALL last exactly one cycle and then go to WAIT.
REQ-023 Read latency is one cycle: in WAIT, q_b SHALL be captured into out_data at the rising edge that ends WAIT, then go to VALID.
REQ-024 In VALID, out_valid SHALL be 1 and out_data SHALL hold stable until out_valid=1 and out_ready=1 at a rising edge (transfer).
REQ-025 On transfer, count SHALL decrement and cur_addr SHALL increment modulo 2^WIDTH (0xFFFF wraps to 0x0000).
REQ-026 On a transfer with count=1, the FSM SHALL go to FINISH; otherwise it SHALL go to ISSUE.
REQ-027 FINISH SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-028 busy SHALL be 1 in ISSUE, WAIT, VALID and 0 in IDLE and FINISH.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 abort=1 in ISSUE, WAIT or VALID SHALL return the FSM to IDLE at the next edge, clear out_valid, and suppress done; a transfer coinciding with abort SHALL be counted as delivered, but the burst still ends without done.
REQ-031 abort in IDLE or FINISH SHALL have no effect.
REQ-032 Minimum spacing is 3 cycles per word with out_ready held at 1; with length=N and out_ready=1, done SHALL assert 3N+1 cycles after the start edge.

Reset
REQ-033 While reset=0: state=IDLE, cur_addr=0, count=0, out_data=0, out_valid=0, busy=0, done=0, addr_b=0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no done pulse.
REQ-035 After reset releases, the first accepted start SHALL behave exactly as from power-up.

Verification
REQ-036 Preload BRAM[0x10..0x13]=0xA1,0xB2,0xC3,0xD4; start with base=0x10, length=4, out_ready=1 -> out_data sequence 0xA1,0xB2,0xC3,0xD4; each word has one cycle of out_valid; done pulses once, 13 cycles after start.
REQ-037 Same burst with out_ready low for 5 cycles in the second VALID -> 0xB2 held stable with out_valid=1 for 6 cycles; no word lost or duplicated.
REQ-038 length=0 -> no addr_b change and out_valid never 1; done pulses one cycle after start; busy stays 0.
REQ-039 base=0xFFFE, length=3 -> addr_b sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-040 Reset and abort during a burst:
- abort during the second WAIT of a length-4 burst -> IDLE next cycle, out_valid=0, no done.
- reset=0 during the third VALID -> all outputs 0 immediately.
- New start with base=0x20, length=1 -> one correct word, then done.
REQ-041 start pulsed during VALID of an active burst -> ignored; burst length and addresses are unchanged.
